imem_boot_loader: RTL and testbench

Upstream companion of the five-stage processor core. Receives a framed byte stream over a valid/ready interface and writes it as 32-bit words into the instruction memory write port. Holds the core in reset until a complete frame with a valid checksum has been loaded, then releases it. Errors keep the core in reset and re-arm the loader.

---
 rtl/boot_pkg.sv | 18 +
 rtl/boot_word_assembler.sv | 44 ++++
 rtl/imem_boot_loader.sv | 107 ++++++++++
 tb/tb_imem_boot_loader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared constants and state encoding for the instruction-memory boot loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package boot_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        SYNC   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4,
        RUN    = 3'd5,
        ERR    = 3'd6
    } bootState_e;

endpackage

// File: rtl/boot_word_assembler.sv
// Packs payload bytes little-endian into 32-bit words and XORs them into a running checksum.
// Latency: wordDone and word are combinational on the 4th byte; checksum updates on the clock edge.
// Backpressure: none; consumes a byte whenever byteVld is high.
module boot_word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byteVld,
    input  logic [7:0]  byteIn,
    output logic        wordDone,
    output logic [31:0] word,
    output logic [7:0]  csumAcc
);

    logic [1:0]  byteIdx;
    logic [23:0] partial;

    // The 4th byte is not stored; it is forwarded directly into the completed word.
    assign wordDone = byteVld && (byteIdx == 2'd3);
    assign word     = {byteIn, partial};

    // Byte index, partial word and checksum; cleared at the start of each payload.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byteIdx <= 2'd0;
            partial <= 24'd0;
            csumAcc <= 8'd0;
        end else if (clear) begin
            byteIdx <= 2'd0;
            partial <= 24'd0;
            csumAcc <= 8'd0;
        end else if (byteVld) begin
            byteIdx <= byteIdx + 2'd1;
            csumAcc <= csumAcc ^ byteIn;
            case (byteIdx)
                2'd0:    partial[7:0]   <= byteIn;
                2'd1:    partial[15:8]  <= byteIn;
                2'd2:    partial[23:16] <= byteIn;
                default: partial        <= partial;
            endcase
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a framed, checksummed byte stream into instruction memory and releases the core on success.
// Latency: one imem write per word, issued the cycle after its 4th byte; core released the cycle after the checksum byte.
// Backpressure: rx_ready is high in every state except RUN; no stalls while loading.
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              boot_done,
    output logic              boot_err,
    output logic [15:0]       word_count
);

    bootState_e  state, stateNext;
    logic [7:0]  lenLo;
    logic [15:0] frameLen;
    logic [15:0] lenIn;
    logic        rxFire;
    logic        syncSeen;
    logic        lenBad;
    logic        lastWord;
    logic        asmClear;
    logic        asmByteVld;
    logic        wordDone;
    logic [31:0] asmWord;
    logic [7:0]  csumAcc;

    assign rxFire     = rx_valid && rx_ready;
    assign syncSeen   = rxFire && (rx_data == SYNC_BYTE);
    assign lenIn      = {rx_data, lenLo};
    assign lenBad     = (lenIn == 16'd0) || (32'(lenIn) > 32'(MAX_WORDS));
    assign asmClear   = (state == LEN_HI) && rxFire;
    assign asmByteVld = (state == DATA) && rxFire;
    assign lastWord   = wordDone && ((word_count + 16'd1) == frameLen);

    boot_word_assembler u_asm (
        .clk      (clk),
        .rst      (rst),
        .clear    (asmClear),
        .byteVld  (asmByteVld),
        .byteIn   (rx_data),
        .wordDone (wordDone),
        .word     (asmWord),
        .csumAcc  (csumAcc)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= SYNC;
        else      state <= stateNext;
    end

    // Frame parsing transitions and state-decoded status outputs.
    always_comb begin
        stateNext  = state;
        rx_ready   = (state != RUN);
        core_rst_n = (state == RUN);
        boot_done  = (state == RUN);
        boot_err   = (state == ERR);
        case (state)
            SYNC, ERR: if (syncSeen) stateNext = LEN_LO;
            LEN_LO:    if (rxFire)   stateNext = LEN_HI;
            LEN_HI:    if (rxFire)   stateNext = lenBad ? ERR : DATA;
            DATA:      if (lastWord) stateNext = CSUM;
            CSUM:      if (rxFire)   stateNext = (rx_data == csumAcc) ? RUN : ERR;
            RUN:       stateNext = RUN;
            default:   stateNext = SYNC;
        endcase
    end

    // Length capture, word counter and the registered memory write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lenLo      <= 8'd0;
            frameLen   <= 16'd0;
            word_count <= 16'd0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
        end else begin
            imem_we <= 1'b0;
            if ((state == SYNC || state == ERR) && syncSeen) word_count <= 16'd0;
            if (state == LEN_LO && rxFire) lenLo <= rx_data;
            if (asmClear) begin
                frameLen   <= lenIn;
                word_count <= 16'd0;
            end
            if (wordDone) begin
                imem_we    <= 1'b1;
                imem_addr  <= word_count[ADDR_W-1:0];
                imem_wdata <= asmWord;
                word_count <= word_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed and randomized frames checked against a frame-level reference model.
// Latency: n/a (testbench).
// Backpressure: waits on rx_ready with a bounded cycle budget.
module tb_imem_boot_loader;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst_n;
    logic        boot_done;
    logic        boot_err;
    logic [15:0] word_count;

    imem_boot_loader dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst_n (core_rst_n),
        .boot_done  (boot_done),
        .boot_err   (boot_err),
        .word_count (word_count)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int stalls = 0;

    logic [7:0]  txQ[$];
    logic [31:0] expWords[$];
    logic [31:0] wq[$];
    logic [9:0]  gotAddr[$];
    logic [31:0] gotData[$];
    int          gotCyc[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Observe every write strobe mid-cycle.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            gotAddr.push_back(imem_addr);
            gotData.push_back(imem_wdata);
            gotCyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference frame: header, little-endian words, XOR of payload bytes (optionally corrupted).
    task automatic buildFrame(input logic [31:0] words[$], input logic [7:0] csumFlip);
        logic [7:0]  cs;
        logic [15:0] n;
        logic [31:0] w;
        cs = 8'h00;
        n  = 16'(words.size());
        txQ.push_back(8'hA5);
        txQ.push_back(n[7:0]);
        txQ.push_back(n[15:8]);
        expWords = words;
        foreach (words[i]) begin
            w = words[i];
            for (int k = 0; k < 4; k++) begin
                txQ.push_back(w[8*k +: 8]);
                cs = cs ^ w[8*k +: 8];
            end
        end
        txQ.push_back(cs ^ csumFlip);
    endtask

    task automatic clearGot();
        gotAddr.delete();
        gotData.delete();
        gotCyc.delete();
    endtask

    task automatic sendBytes(input int maxGap);
        logic [7:0] b;
        int gap;
        int budget;
        while (txQ.size() > 0) begin
            b   = txQ.pop_front();
            gap = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
            @(negedge clk);
            rx_valid = 1'b0;
            repeat (gap) @(negedge clk);
            rx_data  = b;
            rx_valid = 1'b1;
            budget   = 0;
            while (rx_ready !== 1'b1 && budget < 20) begin
                stalls++;
                budget++;
                @(negedge clk);
            end
            if (budget >= 20) begin
                checks++;
                errors++;
                $error("FAIL rx_ready_wait observed timeout expected ready");
                txQ.delete();
                rx_valid = 1'b0;
                return;
            end
            @(posedge clk);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic checkWrites(input string tag);
        chk({tag, "_nwrites"}, gotAddr.size(), expWords.size());
        for (int i = 0; i < gotAddr.size() && i < expWords.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), 32'(gotAddr[i]), i);
            chk($sformatf("%s_data%0d", tag, i), gotData[i], expWords[i]);
        end
    endtask

    task automatic checkStatus(input string tag, input logic done, input logic err, input logic [15:0] wc);
        chk({tag, "_boot_done"},  boot_done,  done);
        chk({tag, "_core_rst_n"}, core_rst_n, done);
        chk({tag, "_rx_ready"},   rx_ready,   !done);
        chk({tag, "_boot_err"},   boot_err,   err);
        chk({tag, "_word_count"}, word_count, wc);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        clearGot();
    endtask

    initial begin
        rst      = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state.
        chk("rst_imem_we",    imem_we,    1'b0);
        chk("rst_imem_addr",  imem_addr,  10'd0);
        chk("rst_imem_wdata", imem_wdata, 32'd0);
        checkStatus("rst", 1'b0, 1'b0, 16'd0);
        @(negedge clk);
        rst = 1'b1;

        // Two-word program.
        clearGot();
        wq = '{32'h0000_0013, 32'h0010_0093};
        buildFrame(wq, 8'h00);
        sendBytes(0);
        checkWrites("t1");
        checkStatus("t1", 1'b1, 1'b0, 16'd2);

        // Bytes offered while running are ignored.
        clearGot();
        rx_data  = 8'hA5;
        rx_valid = 1'b1;
        repeat (5) @(negedge clk);
        rx_valid = 1'b0;
        chk("run_ignore_writes", gotAddr.size(), 0);
        checkStatus("run_ignore", 1'b1, 1'b0, 16'd2);

        // Junk ahead of sync is discarded.
        doReset();
        txQ = '{8'h00, 8'hFF, 8'h5A};
        wq  = '{32'hDEAD_BEEF};
        buildFrame(wq, 8'h00);
        sendBytes(0);
        checkWrites("t2");
        checkStatus("t2", 1'b1, 1'b0, 16'd1);

        // Bad checksum, then recovery with a good frame.
        doReset();
        buildFrame(wq, 8'h01);
        sendBytes(0);
        checkStatus("t3_bad", 1'b0, 1'b1, 16'd1);
        clearGot();
        txQ.push_back(8'hA5);
        sendBytes(0);
        checkStatus("t3_lenlo", 1'b0, 1'b0, 16'd0);
        wq = '{32'hDEAD_BEEF};
        buildFrame(wq, 8'h00);
        void'(txQ.pop_front());
        sendBytes(0);
        checkWrites("t3_good");
        checkStatus("t3_good", 1'b1, 1'b0, 16'd1);

        // Zero length and over-length frames are rejected right after the length.
        doReset();
        txQ = '{8'hA5, 8'h00, 8'h00};
        sendBytes(0);
        checkStatus("t4_zero", 1'b0, 1'b1, 16'd0);
        txQ = '{8'hA5, 8'h01, 8'h04};
        sendBytes(0);
        checkStatus("t4_big", 1'b0, 1'b1, 16'd0);
        repeat (4) @(negedge clk);
        chk("t4_nwrites", gotAddr.size(), 0);

        // Stall mid-word, then asynchronous reset without a clock edge.
        clearGot();
        txQ = '{8'hA5, 8'h05, 8'h00, 8'h11, 8'h22, 8'h33};
        sendBytes(0);
        repeat (50) @(negedge clk);
        chk("t5_stall_writes", gotAddr.size(), 0);
        checkStatus("t5_stall", 1'b0, 1'b0, 16'd0);
        // Make the write-data register non-zero so the reset is observable on it.
        doReset();
        wq = '{32'h0BAD_F00D};
        buildFrame(wq, 8'h00);
        txQ.pop_back();
        sendBytes(0);
        chk("t5_pre_wdata", imem_wdata, 32'h0BAD_F00D);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("t5_async_we",    imem_we,    1'b0);
        chk("t5_async_addr",  imem_addr,  10'd0);
        chk("t5_async_wdata", imem_wdata, 32'd0);
        checkStatus("t5_async", 1'b0, 1'b0, 16'd0);
        @(negedge clk);
        rst = 1'b1;
        clearGot();
        wq.delete();
        for (int i = 0; i < 3; i++) wq.push_back($urandom);
        buildFrame(wq, 8'h00);
        sendBytes(3);
        checkWrites("t5_fresh");
        checkStatus("t5_fresh", 1'b1, 1'b0, 16'd3);

        // Eight words streamed back-to-back.
        doReset();
        stalls = 0;
        wq.delete();
        for (int i = 0; i < 8; i++) wq.push_back($urandom);
        buildFrame(wq, 8'h00);
        sendBytes(0);
        checkWrites("t6");
        checkStatus("t6", 1'b1, 1'b0, 16'd8);
        chk("t6_stalls", stalls, 0);
        for (int i = 1; i < gotCyc.size(); i++)
            chk($sformatf("t6_spacing%0d", i), gotCyc[i] - gotCyc[i-1], 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
